// File: rtl/or1200_alarm_responder.sv
// Alarm responder: turns the privilege-checker aggregate alarm into a stall,
// a timed core reset request, a sticky cause record and an episode count with lockout.
module or1200_alarm_responder #(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned LOCK_THRESHOLD = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alarm,
  input  logic [5:0]       fail_vec,
  input  logic             ack,
  output logic             cpu_stall,
  output logic             cpu_rst_req,
  output logic [5:0]       cause,
  output logic [CNT_W-1:0] alarm_count,
  output logic             locked
);

  localparam int unsigned HOLD_W = 8;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  LOCK_LVL  = CNT_W'(LOCK_THRESHOLD);

  typedef enum logic [2:0] {
    IDLE,
    STALL,
    RESET,
    WAIT_ACK,
    LOCKED
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold;

  // Saturating episode counter increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Further alarms inside an episode only widen the cause record.
  logic [5:0] cause_acc;
  assign cause_acc = alarm ? (cause | fail_vec) : cause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold        <= '0;
      cpu_stall   <= 1'b0;
      cpu_rst_req <= 1'b0;
      cause       <= '0;
      alarm_count <= '0;
      locked      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (alarm) begin
            cause       <= fail_vec;
            alarm_count <= sat_inc(alarm_count);
            cpu_stall   <= 1'b1;
            state       <= STALL;
          end
        end

        STALL: begin
          cause       <= cause_acc;
          hold        <= HOLD_LOAD;
          cpu_rst_req <= 1'b1;
          state       <= RESET;
        end

        RESET: begin
          cause <= cause_acc;
          if (hold == '0) begin
            cpu_rst_req <= 1'b0;
            state       <= WAIT_ACK;
          end else begin
            hold <= hold - HOLD_W'(1);
          end
        end

        WAIT_ACK: begin
          if (!ack) begin
            cause <= cause_acc;
          end else if (alarm_count >= LOCK_LVL) begin
            cause  <= cause_acc;
            locked <= 1'b1;
            state  <= LOCKED;
          end else if (alarm) begin
            // Back-to-back episode: stall is held, no return through IDLE.
            cause       <= fail_vec;
            alarm_count <= sat_inc(alarm_count);
            state       <= STALL;
          end else begin
            cause     <= '0;
            cpu_stall <= 1'b0;
            state     <= IDLE;
          end
        end

        LOCKED: begin
          cpu_stall <= 1'b1;
          locked    <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          cpu_stall   <= 1'b0;
          cpu_rst_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/or1200_alarm_responder.md
# or1200_alarm_responder

Consumes the aggregate alarm from the privilege-checker alarm stage and turns it into a controlled CPU response. It stalls the core, issues a timed reset request, records which assertion fired, and counts alarm episodes. It then waits for an external recovery agent to acknowledge. Repeated episodes lock the core down until hardware reset. It sits between the checker alarm output and the OR1200 top-level stall/reset logic.

## Interface
- HOLD_CYCLES, 16, cycles cpu_rst_req stays asserted per episode; legal range 1..255.
- LOCK_THRESHOLD, 3, episode count at which the block enters permanent lockout; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of alarm_count.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alarm  in  1  aggregate alarm from checker stage (high = some assertion failed).
- fail_vec  in  6  per-assertion failure bits, each the inverse of its ok flag: [5] immu_fault, [4] dmmu_fault, [3] supv_consistent, [2] sr, [1] pipeline, [0] mmus.
- ack  in  1  single-cycle acknowledge from recovery agent.
- cpu_stall  out  1  stall request to core pipeline.
- cpu_rst_req  out  1  reset request to core.
- cause  out  6  sticky record of failing assertions for the current episode.
- alarm_count  out  CNT_W  saturating count of alarm episodes since rst.
- locked  out  1  permanent lockout indicator.

## Operation
- States: IDLE, STALL, RESET, WAIT_ACK, LOCKED. All outputs are registered.
- Reset values: state=IDLE, cpu_stall=0, cpu_rst_req=0, cause=0, alarm_count=0, locked=0, hold counter=0. Asserting rst mid-episode aborts the episode immediately, with no residual outputs.
- IDLE: alarm=1 starts an episode:
  - cause <= fail_vec.
  - alarm_count <= alarm_count+1, saturating at 2^CNT_W-1.
  - Next state STALL.
  - ack in IDLE is ignored.
- STALL: lasts exactly 1 cycle (pipeline drain). cpu_stall=1. Next state RESET, hold counter loaded with HOLD_CYCLES-1.
- RESET: cpu_stall=1 and cpu_rst_req=1. Hold counter decrements each cycle. When the counter reaches 0, the next state is WAIT_ACK.
- WAIT_ACK: cpu_stall=1, cpu_rst_req=0. Stays here until ack=1, then:
  - if alarm_count >= LOCK_THRESHOLD, go to LOCKED;
  - else if alarm=1 on the same cycle, start a new episode (cause <= fail_vec, count increments, go to STALL);
  - else clear cause and go to IDLE.
- LOCKED: cpu_stall=1, cpu_rst_req=0, locked=1. cause is frozen. ack and alarm are ignored. Only rst exits this state.
- Alarm during STALL/RESET/WAIT_ACK: cause <= cause | fail_vec. The count is not incremented. The episode is not restarted.
- ack outside WAIT_ACK has no effect.
- fail_vec is sampled only when alarm=1. fail_vec bits with alarm=0 never update cause.

## Timing
- alarm sampled high at edge T:
  - cpu_stall=1 from T+1.
  - cpu_rst_req=1 for exactly HOLD_CYCLES cycles, T+2 through T+1+HOLD_CYCLES.
  - WAIT_ACK entered at T+2+HOLD_CYCLES.
- cause and alarm_count update at T+1.
- ack sampled at edge A in WAIT_ACK:
  - cpu_stall=0 and cause=0 from A+1 (IDLE case);
  - locked=1 from A+1 (LOCKED case).
- Single-cycle alarm pulses must be caught; there is no filtering or debounce.
- Minimum episode length, alarm to IDLE, is HOLD_CYCLES+3 cycles.

## Test plan
- Single episode, HOLD_CYCLES=4: pulse alarm with fail_vec=6'b000100 at T, then ack at T+8. Required:
  - cpu_stall high T+1..T+8;
  - cpu_rst_req high T+2..T+5;
  - cause=6'b000100 until T+8, then 0 at T+9;
  - alarm_count=1;
  - locked=0.
- Cause accumulation: alarm with fail_vec=6'b000001, then alarm with fail_vec=6'b100000 during RESET. Required: cause=6'b100001 and alarm_count=1.
- Lockout, LOCKED_THRESHOLD=3: three full episodes, each acked. Required:
  - after the third ack, locked=1 and cpu_stall=1 permanently;
  - further alarm/ack pulses change nothing;
  - rst returns all outputs to 0.
- Back-to-back: alarm and ack both high in the same cycle in WAIT_ACK. Required: state goes straight to STALL, alarm_count increments, cause = new fail_vec, cpu_stall never drops.
- Async reset mid-RESET: assert rst between clock edges. Required: cpu_rst_req, cpu_stall and cause go to 0 immediately, without waiting for a clock edge; the block returns to IDLE.
- Saturation, CNT_W=2, LOCK_THRESHOLD=3: run episodes until the count reaches 3. Required: alarm_count never wraps past 3.
